// File: rtl/sr04_controller.sv
// HC-SR04 ultrasonic ranger controller: trigger generation, echo timing, distance in cm.
// Optional self-trigger is built only when SR04_AUTO_TRIG_EN is defined.
module sr04_controller #(
    parameter int unsigned CLK_FREQ        = 100_000_000,
    parameter int unsigned TRIG_US         = 10,
    parameter int unsigned ECHO_TIMEOUT_US = 30_000,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned AUTO_PERIOD_MS  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic [11:0] distance,
    output logic        done,
    output logic        error,
    output logic        busy
);
    localparam int unsigned DIV    = CLK_FREQ / 1_000_000;
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned US_MAX = (TRIG_US > ECHO_TIMEOUT_US) ? TRIG_US : ECHO_TIMEOUT_US;
    localparam int unsigned US_W   = $clog2(US_MAX + 1);
    localparam int unsigned SUB_W  = $clog2(58);
    localparam int unsigned CM_W   = 12;

    if (CLK_FREQ % 1_000_000 != 0 || TRIG_US == 0 || ECHO_TIMEOUT_US == 0 || AUTO_PERIOD_MS == 0) begin : g_bad_cfg
        $error("sr04_controller: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [CM_W-1:0]   cm_cnt;
    logic              echo_s1;
    logic              echo_s2;
    logic              echo_prev;
    logic              tick_c;
    logic              rise_c;
    logic              fall_c;
    logic              req_c;

    // Two-flop synchronizer plus one more sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1   <= 1'b0;
            echo_s2   <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_s1   <= echo;
            echo_s2   <= echo_s1;
            echo_prev <= echo_s2;
        end
    end

    assign rise_c = echo_s2 & ~echo_prev;
    assign fall_c = ~echo_s2 & echo_prev;
    assign tick_c = (tick_cnt == TICK_W'(DIV - 1));

`ifdef SR04_AUTO_TRIG_EN
    localparam int unsigned PERIOD_CYC = (CLK_FREQ / 1000) * AUTO_PERIOD_MS;
    localparam int unsigned PER_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    logic [PER_W-1:0] per_cnt;
    logic             per_end_c;

    assign per_end_c = (per_cnt == PER_W'(PERIOD_CYC - 1));

    // Free-running period counter; an expiry while busy is simply lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_end_c ? '0 : per_cnt + PER_W'(1);
        end
    end

    assign req_c = start | (per_end_c & ~busy);
`else
    assign req_c = start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            us_cnt   <= '0;
            sub_cnt  <= '0;
            cm_cnt   <= '0;
            trig     <= 1'b0;
            distance <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done     <= 1'b0;
            tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
            case (state)
                S_IDLE: begin
                    // busy is still high for the cycle that carries done
                    busy <= 1'b0;
                    if (req_c && !busy) begin
                        state    <= S_TRIG;
                        trig     <= 1'b1;
                        busy     <= 1'b1;
                        us_cnt   <= '0;
                        tick_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    if (tick_c) begin
                        if (us_cnt == US_W'(TRIG_US - 1)) begin
                            state    <= S_WAIT_ECHO;
                            trig     <= 1'b0;
                            us_cnt   <= '0;
                            tick_cnt <= '0;
                        end else begin
                            us_cnt <= us_cnt + US_W'(1);
                        end
                    end
                end
                S_WAIT_ECHO: begin
                    if (rise_c) begin
                        state    <= S_MEASURE;
                        sub_cnt  <= '0;
                        cm_cnt   <= '0;
                        tick_cnt <= '0;
                    end else if (tick_c) begin
                        if (us_cnt == US_W'(ECHO_TIMEOUT_US - 1)) begin
                            state    <= S_FAIL;
                            tick_cnt <= '0;
                        end else begin
                            us_cnt <= us_cnt + US_W'(1);
                        end
                    end
                end
                S_MEASURE: begin
                    if (fall_c) begin
                        state    <= S_DONE;
                        tick_cnt <= '0;
                    end else if (cm_cnt == CM_W'(MAX_CM + 1)) begin
                        state    <= S_FAIL;
                        tick_cnt <= '0;
                    end
                    // 58 us of echo per centimetre
                    if (tick_c) begin
                        if (sub_cnt == SUB_W'(57)) begin
                            sub_cnt <= '0;
                            cm_cnt  <= cm_cnt + CM_W'(1);
                        end else begin
                            sub_cnt <= sub_cnt + SUB_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    distance <= cm_cnt;
                    error    <= 1'b0;
                    done     <= 1'b1;
                    tick_cnt <= '0;
                end
                S_FAIL: begin
                    state    <= S_IDLE;
                    error    <= 1'b1;
                    done     <= 1'b1;
                    tick_cnt <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sr04_controller.sv
// Directed self-checking bench for sr04_controller at a scaled-down clock (2 MHz, 2 cycles per us).
module tb_sr04_controller;
    localparam int unsigned CLK_FREQ   = 2_000_000;
    localparam int unsigned DIV        = 2;
    localparam int unsigned TRIG_US    = 10;
    localparam int unsigned TIMEOUT_US = 1000;
    localparam int unsigned MAX_CM     = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        echo = 1'b0;
    logic        trig;
    logic [11:0] distance;
    logic        done;
    logic        error;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [11:0] cap_dist = '0;
    logic        cap_err = 1'b0;

    always #5 clk = ~clk;

    sr04_controller #(
        .CLK_FREQ       (CLK_FREQ),
        .TRIG_US        (TRIG_US),
        .ECHO_TIMEOUT_US(TIMEOUT_US),
        .MAX_CM         (MAX_CM),
        .AUTO_PERIOD_MS (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .echo    (echo),
        .trig    (trig),
        .distance(distance),
        .done    (done),
        .error   (error),
        .busy    (busy)
    );

    // Count done strobes and capture the result they present
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            cap_dist = distance;
            cap_err  = error;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_trig_low(output int n);
        n = 0;
        while (trig && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic measure(input string tag, input int delay_us, input int width_us, input bit spam,
                           input logic [11:0] exp_d, input logic exp_e);
        int d0;
        int n;
        d0 = done_cnt;
        pulse_start();
        wait_trig_low(n);
        repeat (delay_us * DIV) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < width_us * int'(DIV); i++) begin
            @(negedge clk);
            start = (spam && (i % 400) == 100) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        echo  = 1'b0;
        wait_idle({tag, "_idle"}, 50);
        repeat (4) @(negedge clk);
        check({tag, "_dones"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_dist"}, 32'(cap_dist), 32'(exp_d));
        check({tag, "_err"}, 32'(cap_err), 32'(exp_e));
    endtask

    initial begin
        int n;
        int d0;

        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_dist", 32'(distance), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // No echo: trigger width, then timeout failure
        d0 = done_cnt;
        pulse_start();
        check("trig_on", 32'(trig), 32'd1);
        check("busy_on", 32'(busy), 32'd1);
        wait_trig_low(n);
        check("trig_width", 32'(n), 32'(TRIG_US * DIV));
        n = 0;
        while (!done && n < 2 * TIMEOUT_US * DIV) begin
            @(negedge clk);
            n++;
        end
        check("to_done", 32'(done), 32'd1);
        check("to_busy_with_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("to_done_drop", 32'(done), 32'd0);
        check("to_busy_drop", 32'(busy), 32'd0);
        check("to_dones", 32'(done_cnt - d0), 32'd1);
        check("to_err", 32'(error), 32'd1);
        check("to_dist", 32'(distance), 32'd0);

        // Valid widths, including the largest in-range distance; starts during MEASURE are ignored
        measure("w5830", 200, 5830, 1'b1, 12'd100, 1'b0);
        measure("w87", 30, 87, 1'b0, 12'd1, 1'b0);
        measure("w7000", 50, 7000, 1'b0, 12'd120, 1'b0);
        // Over range: fails at 121 cm and keeps the previous distance
        measure("w7100", 50, 7100, 1'b0, 12'd120, 1'b1);

        // Reset during TRIG
        d0 = done_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        check("rt_trig_before", 32'(trig), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rt_trig_async", 32'(trig), 32'd0);
        check("rt_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rt_no_done", 32'(done_cnt - d0), 32'd0);
        check("rt_trig_idle", 32'(trig), 32'd0);
        check("rt_dist", 32'(distance), 32'd0);
        check("rt_err", 32'(error), 32'd0);

        // Recovery after reset
        measure("w194", 20, 194, 1'b0, 12'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
